// File: rtl/add_result_buffer.sv
// rtl/add_result_buffer.sv - FWFT result FIFO behind the 16-bit CLA adder with per-entry flags and sticky overflow
// Optional ADD_RESULT_STATS_EN adds a saturating 16-bit overflow event counter (ovf_count).
module add_result_buffer #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_sum,
  input  logic                     in_overflow,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_sum,
  output logic                     out_overflow,
  output logic                     out_zero,
  output logic                     out_neg,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     sticky_ovf,
  input  logic                     clr_sticky
`ifdef ADD_RESULT_STATS_EN
  ,
  output logic [15:0]              ovf_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = WIDTH + 3;

  // Entry layout: {overflow, zero, neg, sum}; flags are derived once at push time.
  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [EW-1:0] head;
  logic          push;
  logic          pop;

  assign in_ready  = (count != CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {in_overflow, ~|in_sum, in_sum[WIDTH-1], in_sum};
    end
  end

  // DEPTH is a power of two, so pointer wrap is plain modular increment.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

  always_comb begin
    out_sum      = '0;
    out_overflow = 1'b0;
    out_zero     = 1'b0;
    out_neg      = 1'b0;
    if (out_valid) begin
      out_sum      = head[WIDTH-1:0];
      out_neg      = head[WIDTH];
      out_zero     = head[WIDTH+1];
      out_overflow = head[WIDTH+2];
    end
  end

  // A new overflow in the same cycle as a clear must survive the clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sticky_ovf <= 1'b0;
    end else if (push && in_overflow) begin
      sticky_ovf <= 1'b1;
    end else if (clr_sticky) begin
      sticky_ovf <= 1'b0;
    end
  end

`ifdef ADD_RESULT_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_count <= '0;
    end else if (push && in_overflow) begin
      if (clr_sticky) begin
        ovf_count <= 16'd1;
      end else if (ovf_count != 16'hFFFF) begin
        ovf_count <= ovf_count + 16'd1;
      end
    end else if (clr_sticky) begin
      ovf_count <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_add_result_buffer.sv
// tb/tb_add_result_buffer.sv - directed and random checks of add_result_buffer against a queue reference model
module tb_add_result_buffer;

  localparam int W = 16;
  localparam int D = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_sum;
  logic          in_overflow;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_sum;
  logic          out_overflow;
  logic          out_zero;
  logic          out_neg;
  logic [2:0]    count;
  logic          sticky_ovf;
  logic          clr_sticky;
`ifdef ADD_RESULT_STATS_EN
  logic [15:0]   ovf_count;
`endif

  always #5 clk = ~clk;

  add_result_buffer #(.WIDTH(W), .DEPTH(D)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_sum       (in_sum),
    .in_overflow  (in_overflow),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_sum      (out_sum),
    .out_overflow (out_overflow),
    .out_zero     (out_zero),
    .out_neg      (out_neg),
    .count        (count),
    .sticky_ovf   (sticky_ovf),
    .clr_sticky   (clr_sticky)
`ifdef ADD_RESULT_STATS_EN
    ,
    .ovf_count    (ovf_count)
`endif
  );

  typedef struct packed {
    logic [W-1:0] sum;
    logic         ovf;
  } ent_t;

  ent_t        q[$];
  bit          m_sticky;
  int unsigned m_ovfc;
  int          checks = 0;
  int          passed = 0;
  int          fails  = 0;
  bit          chk_en = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [W-1:0] e_sum;
    logic         e_ovf;
    if (!chk_en) return;
    e_sum = '0;
    e_ovf = 1'b0;
    if (q.size() > 0) begin
      e_sum = q[0].sum;
      e_ovf = q[0].ovf;
    end
    chk("count",     32'(count),        32'(q.size()));
    chk("out_valid", 32'(out_valid),    32'(q.size() > 0));
    chk("in_ready",  32'(in_ready),     32'(q.size() < D));
    chk("out_sum",   32'(out_sum),      32'(e_sum));
    chk("out_ovf",   32'(out_overflow), 32'(e_ovf));
    chk("out_zero",  32'(out_zero),     32'((q.size() > 0) && (e_sum == 0)));
    chk("out_neg",   32'(out_neg),      32'((q.size() > 0) && (e_sum >= 16'h8000)));
    chk("sticky",    32'(sticky_ovf),   32'(m_sticky));
`ifdef ADD_RESULT_STATS_EN
    chk("ovf_count", 32'(ovf_count),    32'(m_ovfc));
`endif
  endtask

  // One clock: decide the transfer from the pre-edge model, advance, then compare #1 after the edge.
  task automatic cycle();
    bit   do_push, do_pop, ovf_ev;
    ent_t e;
    do_push = rst_n && in_valid && (q.size() < D);
    do_pop  = rst_n && out_ready && (q.size() > 0);
    ovf_ev  = do_push && in_overflow;
    e.sum   = in_sum;
    e.ovf   = in_overflow;
    @(posedge clk);
    if (!rst_n) begin
      q.delete();
      m_sticky = 1'b0;
      m_ovfc   = 0;
    end else begin
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(e);
      if (ovf_ev) m_sticky = 1'b1;
      else if (clr_sticky) m_sticky = 1'b0;
      if (ovf_ev && clr_sticky) m_ovfc = 1;
      else if (ovf_ev) m_ovfc = (m_ovfc == 32'hFFFF) ? m_ovfc : m_ovfc + 1;
      else if (clr_sticky) m_ovfc = 0;
    end
    #1;
    check_all();
  endtask

  task automatic drive(input logic v, input logic [W-1:0] s, input logic o);
    in_valid    = v;
    in_sum      = s;
    in_overflow = o;
  endtask

  function automatic logic [W-1:0] rand_sum();
    case ($urandom_range(0, 3))
      0:       return '0;
      1:       return 16'h8000 | W'($urandom);
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    rst_n = 1'b0; out_ready = 1'b0; clr_sticky = 1'b0;
    drive(1'b1, 16'hAAAA, 1'b1);
    cycle();
    cycle();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_sticky", 32'(sticky_ovf), 32'd0);
    rst_n = 1'b1;
    drive(1'b0, '0, 1'b0);
    cycle();

    drive(1'b1, 16'h1234, 1'b0); cycle();
    drive(1'b1, 16'h0000, 1'b0); cycle();
    chk("sticky_pre", 32'(sticky_ovf), 32'd0);
    drive(1'b1, 16'h8001, 1'b1); cycle();
    drive(1'b0, '0, 1'b0);
    chk("t2_count", 32'(count), 32'd3);
    chk("t2_sticky", 32'(sticky_ovf), 32'd1);
    chk("t2_head", 32'(out_sum), 32'h1234);
    cycle();
    chk("t2_hold", 32'(out_sum), 32'h1234);
    out_ready = 1'b1;
    cycle();
    chk("t2_zero", 32'(out_zero), 32'd1);
    cycle();
    chk("t2_neg", 32'({out_neg, out_overflow}), 32'd3);
    cycle();
    chk("t2_empty", 32'(out_valid), 32'd0);

    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, rand_sum(), 1'($urandom_range(0, 1)));
      cycle();
    end
    drive(1'b1, 16'hDEAD, 1'b0);
    cycle();
    chk("t3_full_rdy", 32'(in_ready), 32'd0);
    chk("t3_full_cnt", 32'(count), 32'd4);
    out_ready = 1'b1;
    cycle();
    chk("t3_pop_only", 32'(count), 32'd3);
    cycle();
    chk("t3_push_pop", 32'(count), 32'd3);
    drive(1'b0, '0, 1'b0);
    for (int i = 0; i < 6 && q.size() > 0; i++) cycle();
    chk("t3_drained", 32'(count), 32'd0);

    for (int i = 0; i < 10; i++) begin
      drive(1'b1, rand_sum(), 1'($urandom_range(0, 1)));
      cycle();
      chk("t4_stream_cnt", 32'(count), 32'd1);
    end
    drive(1'b0, '0, 1'b0);
    cycle();

    clr_sticky = 1'b1;
    drive(1'b1, 16'h0F0F, 1'b1);
    cycle();
    chk("t5_set_wins", 32'(sticky_ovf), 32'd1);
    drive(1'b0, '0, 1'b0);
    cycle();
    chk("t5_clear", 32'(sticky_ovf), 32'd0);
    clr_sticky = 1'b0;

    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, rand_sum(), 1'b1);
      cycle();
    end
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    drive(1'b0, '0, 1'b0);
    cycle();
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_sticky", 32'(sticky_ovf), 32'd0);

    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), rand_sum(), 1'($urandom_range(0, 4) == 0));
      out_ready  = 1'($urandom_range(0, 2) != 0);
      clr_sticky = 1'($urandom_range(0, 15) == 0);
      cycle();
    end
    clr_sticky = 1'b0;
    drive(1'b0, '0, 1'b0);
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) cycle();

`ifdef ADD_RESULT_STATS_EN
    clr_sticky = 1'b1;
    cycle();
    clr_sticky = 1'b0;
    chk_en = 1'b0;
    drive(1'b1, 16'h0001, 1'b1);
    for (int i = 0; i < 65534; i++) cycle();
    chk_en = 1'b1;
    drive(1'b0, '0, 1'b0);
    cycle();
    chk("t6_preload", 32'(ovf_count), 32'hFFFE);
    drive(1'b1, 16'h0002, 1'b1);
    for (int i = 0; i < 3; i++) cycle();
    drive(1'b0, '0, 1'b0);
    cycle();
    chk("t6_saturate", 32'(ovf_count), 32'hFFFF);
    clr_sticky = 1'b1;
    cycle();
    clr_sticky = 1'b0;
    chk("t6_clear", 32'(ovf_count), 32'd0);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
